// File: rtl/fc_rx_dllp_decoder_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the receive-side flow-control DLLP decoder:
//   - DLLP byte0 classification enums (FC kind, credit type)
//   - link-level FC initialization state encoding
//   - byte0 / byte-lane bitfield positions within the 32-bit DLLP word
//   - credit field widths
//   - helper mapping a credit type to its bit in a seen mask
// ---------------------------------------------------------------------------
package fc_pkg;

  localparam int HDR_CREDIT_W  = 8;
  localparam int DATA_CREDIT_W = 12;

  // byte0 occupies [31:24] of the DLLP word; positions below are within byte0
  localparam int B0_KIND_HI = 7;
  localparam int B0_KIND_LO = 6;
  localparam int B0_TYPE_HI = 5;
  localparam int B0_TYPE_LO = 4;

  // byte lanes within the 32-bit DLLP word
  localparam int BYTE0_LSB = 24;
  localparam int BYTE1_LSB = 16;
  localparam int BYTE2_LSB = 8;
  localparam int BYTE3_LSB = 0;

  typedef enum logic [1:0] {
    FC_MWR  = 2'b00,  // posted
    FC_MRD  = 2'b01,  // non-posted
    FC_CPL  = 2'b10,  // completion
    FC_RSVD = 2'b11   // malformed when seen on an FC DLLP
  } fc_type_e;

  typedef enum logic [1:0] {
    DLLP_NOT_FC = 2'b00,
    INITFC1     = 2'b01,
    UPDATEFC    = 2'b10,
    INITFC2     = 2'b11
  } dllp_fc_kind_e;

  typedef enum logic [1:0] {
    FC_IDLE   = 2'b00,
    FC_INIT1  = 2'b01,
    FC_INIT2  = 2'b10,
    FC_ACTIVE = 2'b11
  } fc_state_e;

  // One-hot position of a credit type inside a 3-bit seen mask.
  function automatic logic [2:0] fc_type_onehot(input fc_type_e t);
    logic [2:0] oh;
    oh = 3'b000;
    case (t)
      FC_MWR:  oh = 3'b001;
      FC_MRD:  oh = 3'b010;
      FC_CPL:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/fc_rx_dllp_field_extract.sv
// ---------------------------------------------------------------------------
// fc_rx_dllp_field_extract
// Purely combinational decode of one DLLP word: classifies byte0 into an FC
// kind and credit type, flags malformed FC DLLPs (type 11) and pulls out the
// HdrFC and DataFC credit fields.
//
// Ports:
//   dllp_data_i  in  32            DLLP bytes 0..3, byte0 = [31:24]
//   kind_o       out 2             FC kind (not-FC / InitFC1 / InitFC2 / UpdateFC)
//   type_o       out 2             credit type from byte0[5:4]
//   malformed_o  out 1             FC DLLP carrying the reserved type 11
//   hdr_o        out HDR_CREDIT_W  {byte1[5:0], byte2[7:6]}
//   data_o       out DATA_CREDIT_W {byte2[3:0], byte3[7:0]}
// ---------------------------------------------------------------------------
module fc_rx_dllp_field_extract
  import fc_pkg::*;
(
  input  logic [31:0]              dllp_data_i,
  output dllp_fc_kind_e            kind_o,
  output fc_type_e                 type_o,
  output logic                     malformed_o,
  output logic [HDR_CREDIT_W-1:0]  hdr_o,
  output logic [DATA_CREDIT_W-1:0] data_o
);

  logic [7:0] byte0;
  logic [7:0] byte1;
  logic [7:0] byte2;
  logic [7:0] byte3;

  assign byte0 = dllp_data_i[BYTE0_LSB +: 8];
  assign byte1 = dllp_data_i[BYTE1_LSB +: 8];
  assign byte2 = dllp_data_i[BYTE2_LSB +: 8];
  assign byte3 = dllp_data_i[BYTE3_LSB +: 8];

  assign kind_o = dllp_fc_kind_e'(byte0[B0_KIND_HI:B0_KIND_LO]);
  assign type_o = fc_type_e'(byte0[B0_TYPE_HI:B0_TYPE_LO]);

  // Reserved type only matters on FC DLLPs; non-FC DLLPs are ignored upstream.
  assign malformed_o = (kind_o != DLLP_NOT_FC) && (type_o == FC_RSVD);

  assign hdr_o  = {byte1[5:0], byte2[7:6]};
  assign data_o = {byte2[3:0], byte3};

  // Bits of the DLLP that carry no FC information (VC id, reserved bits).
  logic unused_bits;
  assign unused_bits = ^{byte0[3:0], byte1[7:6], byte2[5:4]};

endmodule

// File: rtl/fc_rx_dllp_decoder.sv
// ---------------------------------------------------------------------------
// fc_rx_dllp_decoder
// Receive-side flow-control DLLP decoder. Classifies incoming DLLPs, runs the
// link-level FC initialization sequence (FC_INIT1 -> FC_INIT2 -> FC_ACTIVE),
// forwards InitFC1 / UpdateFC credits to the TX flow-control controller,
// paces local InitFC transmission requests and counts dropped DLLPs.
// All outputs are registered: a DLLP accepted in cycle N shows in cycle N+1.
//
// Ports:
//   clk              in  1   clock
//   rst_n            in  1   asynchronous active-low reset
//   link_up_i        in  1   DL link up; low forces re-initialization
//   dllp_valid_i     in  1   one DLLP present this cycle
//   dllp_data_i      in  32  DLLP bytes 0..3, byte0 = [31:24]
//   dllp_crc_ok_i    in  1   upstream CRC-16 passed; qualifies dllp_valid_i
//   hdr_credit_o     out 8   last forwarded HdrFC
//   data_credit_o    out 12  last forwarded DataFC
//   is_initFC_o      out 1   pulse: InitFC1 forwarded
//   is_updateFC_o    out 1   pulse: UpdateFC forwarded
//   type_credit_o    out 2   last forwarded credit type (00 P, 01 NP, 10 Cpl)
//   fc_state_o       out 2   FC init state
//   fc_init_done_o   out 1   high in FC_ACTIVE
//   tx_initfc_req_o  out 1   pulse: transmit local InitFC set for current phase
//   drop_cnt_o       out DROP_CNT_W  saturating dropped-DLLP count
// ---------------------------------------------------------------------------
module fc_rx_dllp_decoder
  import fc_pkg::*;
#(
  parameter int INITFC_PERIOD = 64,
  parameter int DROP_CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     link_up_i,
  input  logic                     dllp_valid_i,
  input  logic [31:0]              dllp_data_i,
  input  logic                     dllp_crc_ok_i,
  output logic [HDR_CREDIT_W-1:0]  hdr_credit_o,
  output logic [DATA_CREDIT_W-1:0] data_credit_o,
  output logic                     is_initFC_o,
  output logic                     is_updateFC_o,
  output logic [1:0]               type_credit_o,
  output logic [1:0]               fc_state_o,
  output logic                     fc_init_done_o,
  output logic                     tx_initfc_req_o,
  output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

  localparam int CNT_W = (INITFC_PERIOD > 2) ? $clog2(INITFC_PERIOD) : 1;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  // Field decode
  dllp_fc_kind_e            kind;
  fc_type_e                 dllp_type;
  logic                     malformed;
  logic [HDR_CREDIT_W-1:0]  dllp_hdr;
  logic [DATA_CREDIT_W-1:0] dllp_data;
  logic [2:0]               type_oh;

  fc_rx_dllp_field_extract u_extract (
    .dllp_data_i (dllp_data_i),
    .kind_o      (kind),
    .type_o      (dllp_type),
    .malformed_o (malformed),
    .hdr_o       (dllp_hdr),
    .data_o      (dllp_data)
  );

  assign type_oh = fc_type_onehot(dllp_type);

  // State and output registers
  fc_state_e                state_q,  state_d;
  logic [2:0]               seen1_q,  seen1_d;
  logic [2:0]               seen2_q,  seen2_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;
  logic                     req_q,    req_d;
  logic                     init_q,   init_d;
  logic                     upd_q,    upd_d;
  logic [HDR_CREDIT_W-1:0]  hdr_q,    hdr_d;
  logic [DATA_CREDIT_W-1:0] data_q,   data_d;
  fc_type_e                 type_q,   type_d;
  logic [DROP_CNT_W-1:0]    drop_q,   drop_d;

  logic dllp_ok;
  logic drop_inc;
  logic pace_wrap;

  // A DLLP is usable only when valid, CRC-clean and well formed.
  assign dllp_ok   = dllp_valid_i && dllp_crc_ok_i && !malformed;
  assign pace_wrap = (cnt_q == CNT_W'(INITFC_PERIOD - 1));

  always_comb begin
    state_d  = state_q;
    seen1_d  = seen1_q;
    seen2_d  = seen2_q;
    cnt_d    = cnt_q;
    req_d    = 1'b0;
    init_d   = 1'b0;
    upd_d    = 1'b0;
    hdr_d    = hdr_q;
    data_d   = data_q;
    type_d   = type_q;
    drop_inc = 1'b0;

    if (!link_up_i) begin
      // Link loss wins over everything, including a DLLP arriving this cycle.
      state_d = FC_IDLE;
      seen1_d = 3'b000;
      seen2_d = 3'b000;
      cnt_d   = '0;
    end else begin
      if (dllp_valid_i && (!dllp_crc_ok_i || malformed)) begin
        drop_inc = 1'b1;
      end

      case (state_q)
        FC_IDLE: begin
          state_d = FC_INIT1;
          cnt_d   = '0;
          req_d   = 1'b1;
        end

        FC_INIT1: begin
          if (dllp_ok && (kind == UPDATEFC)) begin
            drop_inc = 1'b1;
          end else if (dllp_ok && (kind == INITFC1) && ((seen1_q & type_oh) == 3'b000)) begin
            init_d  = 1'b1;
            seen1_d = seen1_q | type_oh;
          end

          if (seen1_d == 3'b111) begin
            state_d = FC_INIT2;
            cnt_d   = '0;
            req_d   = 1'b1;
          end else begin
            cnt_d = pace_wrap ? '0 : cnt_q + CNT_W'(1);
            req_d = pace_wrap;
          end
        end

        FC_INIT2: begin
          // The far end reaching FC_ACTIVE first is signalled by its UpdateFC.
          if (dllp_ok && (kind == UPDATEFC)) begin
            upd_d   = 1'b1;
            state_d = FC_ACTIVE;
            cnt_d   = '0;
          end else begin
            if (dllp_ok && (kind == INITFC2)) begin
              seen2_d = seen2_q | type_oh;
            end
            if (seen2_d == 3'b111) begin
              state_d = FC_ACTIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = pace_wrap ? '0 : cnt_q + CNT_W'(1);
              req_d = pace_wrap;
            end
          end
        end

        FC_ACTIVE: begin
          if (dllp_ok && (kind == UPDATEFC)) begin
            upd_d = 1'b1;
          end
        end

        default: begin
          state_d = FC_IDLE;
        end
      endcase

      if (init_d || upd_d) begin
        hdr_d  = dllp_hdr;
        data_d = dllp_data;
        type_d = dllp_type;
      end
    end
  end

  assign drop_d = drop_inc ? sat_inc(drop_q) : drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FC_IDLE;
      seen1_q <= 3'b000;
      seen2_q <= 3'b000;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      init_q  <= 1'b0;
      upd_q   <= 1'b0;
      hdr_q   <= '0;
      data_q  <= '0;
      type_q  <= FC_MWR;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      seen1_q <= seen1_d;
      seen2_q <= seen2_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      init_q  <= init_d;
      upd_q   <= upd_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      type_q  <= type_d;
      drop_q  <= drop_d;
    end
  end

  assign hdr_credit_o    = hdr_q;
  assign data_credit_o   = data_q;
  assign is_initFC_o     = init_q;
  assign is_updateFC_o   = upd_q;
  assign type_credit_o   = type_q;
  assign fc_state_o      = state_q;
  assign fc_init_done_o  = (state_q == FC_ACTIVE);
  assign tx_initfc_req_o = req_q;
  assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_fc_rx_dllp_decoder.sv
module tb_fc_rx_dllp_decoder;

  localparam int PERIOD = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_up;
  logic        dllp_valid;
  logic [31:0] dllp_data;
  logic        dllp_crc_ok;

  logic [7:0]  hdr_credit_o;
  logic [11:0] data_credit_o;
  logic        is_initFC_o;
  logic        is_updateFC_o;
  logic [1:0]  type_credit_o;
  logic [1:0]  fc_state_o;
  logic        fc_init_done_o;
  logic        tx_initfc_req_o;
  logic [7:0]  drop_cnt_o;

  always #5 clk = ~clk;

  fc_rx_dllp_decoder #(.INITFC_PERIOD(PERIOD), .DROP_CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .link_up_i       (link_up),
    .dllp_valid_i    (dllp_valid),
    .dllp_data_i     (dllp_data),
    .dllp_crc_ok_i   (dllp_crc_ok),
    .hdr_credit_o    (hdr_credit_o),
    .data_credit_o   (data_credit_o),
    .is_initFC_o     (is_initFC_o),
    .is_updateFC_o   (is_updateFC_o),
    .type_credit_o   (type_credit_o),
    .fc_state_o      (fc_state_o),
    .fc_init_done_o  (fc_init_done_o),
    .tx_initfc_req_o (tx_initfc_req_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks what the outputs must be one cycle after the inputs it sees.
  // Pacing is expressed as "cycles spent in the current INIT phase".
  typedef struct packed {
    logic [1:0]  st;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [31:0] age;
    logic [7:0]  hdr;
    logic [11:0] dat;
    logic [1:0]  typ;
    logic        init;
    logic        upd;
    logic        req;
    logic [7:0]  drop;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t cur, input logic lu, input logic v,
                                        input logic [31:0] d, input logic crc);
    model_t n;
    int b0, b1, b2, b3, kind, typ, ns;
    bit mal, ok, drop;
    n = cur;
    n.init = 1'b0;
    n.upd  = 1'b0;
    n.req  = 1'b0;
    if (!lu) begin
      n.st = 2'd0; n.s1 = 3'd0; n.s2 = 3'd0; n.age = 0;
      return n;
    end
    b0 = int'(d >> 24) & 255;
    b1 = int'(d >> 16) & 255;
    b2 = int'(d >> 8) & 255;
    b3 = int'(d) & 255;
    kind = b0 / 64;
    typ  = (b0 / 16) % 4;
    mal  = v && (kind != 0) && (typ == 3);
    ok   = v && crc && !mal;
    drop = v && (!crc || mal);
    ns   = int'(cur.st);
    case (int'(cur.st))
      0: ns = 1;
      1: begin
        if (ok && kind == 2) drop = 1'b1;
        else if (ok && kind == 1 && !cur.s1[typ]) begin
          n.s1[typ] = 1'b1;
          n.init = 1'b1;
        end
        if (n.s1 == 3'b111) ns = 2;
      end
      2: begin
        if (ok && kind == 2) begin
          n.upd = 1'b1;
          ns = 3;
        end else begin
          if (ok && kind == 3) n.s2[typ] = 1'b1;
          if (n.s2 == 3'b111) ns = 3;
        end
      end
      default: if (ok && kind == 2) n.upd = 1'b1;
    endcase
    if (drop && cur.drop != 8'hFF) n.drop = cur.drop + 8'd1;
    if (n.init || n.upd) begin
      n.hdr = 8'((b1 % 64) * 4 + b2 / 64);
      n.dat = 12'((b2 % 16) * 256 + b3);
      n.typ = 2'(typ);
    end
    n.age = (ns == int'(cur.st)) ? cur.age + 1 : 0;
    n.st  = 2'(ns);
    n.req = (ns == 1 || ns == 2) && (n.age % PERIOD == 0);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, link_up, dllp_valid, dllp_data, dllp_crc_ok);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc state", int'(fc_state_o),      int'(m.st));
      chk("cyc done",  int'(fc_init_done_o),  int'(m.st == 2'd3));
      chk("cyc req",   int'(tx_initfc_req_o), int'(m.req));
      chk("cyc init",  int'(is_initFC_o),     int'(m.init));
      chk("cyc upd",   int'(is_updateFC_o),   int'(m.upd));
      chk("cyc hdr",   int'(hdr_credit_o),    int'(m.hdr));
      chk("cyc data",  int'(data_credit_o),   int'(m.dat));
      chk("cyc type",  int'(type_credit_o),   int'(m.typ));
      chk("cyc drop",  int'(drop_cnt_o),      int'(m.drop));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic crc);
    dllp_valid  = 1'b1;
    dllp_data   = d;
    dllp_crc_ok = crc;
    tick();
    dllp_valid  = 1'b0;
    dllp_crc_ok = 1'b0;
  endtask

  initial begin
    int pulses;
    rst_n       = 1'b0;
    link_up     = 1'b0;
    dllp_valid  = 1'b0;
    dllp_data   = 32'h0;
    dllp_crc_ok = 1'b0;
    repeat (3) tick();

    chk("rst hdr",   int'(hdr_credit_o),    0);
    chk("rst data",  int'(data_credit_o),   0);
    chk("rst type",  int'(type_credit_o),   0);
    chk("rst init",  int'(is_initFC_o),     0);
    chk("rst upd",   int'(is_updateFC_o),   0);
    chk("rst state", int'(fc_state_o),      0);
    chk("rst done",  int'(fc_init_done_o),  0);
    chk("rst req",   int'(tx_initfc_req_o), 0);
    chk("rst drop",  int'(drop_cnt_o),      0);

    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (2) tick();
    chk("idle state", int'(fc_state_o), 0);

    // Link up: first INIT1 cycle requests InitFC, then every PERIOD cycles
    link_up = 1'b1;
    tick();
    chk("init1 entry state", int'(fc_state_o), 1);
    chk("init1 entry req",   int'(tx_initfc_req_o), 1);
    pulses = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      tick();
      if (tx_initfc_req_o) pulses++;
      if (i == PERIOD) chk("pace 64th", int'(tx_initfc_req_o), 1);
    end
    chk("pace count init1", pulses, 1);

    // InitFC1 P
    send(32'h4001_4080, 1'b1);
    chk("P init", int'(is_initFC_o), 1);
    chk("P hdr",  int'(hdr_credit_o), 8'h05);
    chk("P data", int'(data_credit_o), 12'h080);
    chk("P type", int'(type_credit_o), 0);
    // Duplicate: silently ignored
    send(32'h4001_4080, 1'b1);
    chk("dup init", int'(is_initFC_o), 0);
    chk("dup drop", int'(drop_cnt_o), 0);
    // Bad CRC
    send(32'h4001_4080, 1'b0);
    chk("crc drop", int'(drop_cnt_o), 1);
    // UpdateFC in INIT1
    send(32'h8001_0203, 1'b1);
    chk("upd-in-init1 drop", int'(drop_cnt_o), 2);
    chk("upd-in-init1 upd",  int'(is_updateFC_o), 0);
    // Malformed type 11
    send(32'h7000_0000, 1'b1);
    chk("malformed drop", int'(drop_cnt_o), 3);
    // InitFC1 NP
    send(32'h5003_0405, 1'b1);
    chk("NP init", int'(is_initFC_o), 1);
    chk("NP hdr",  int'(hdr_credit_o), 8'h0C);
    chk("NP data", int'(data_credit_o), 12'h405);
    chk("NP type", int'(type_credit_o), 1);
    // InitFC1 Cpl with infinite credits -> INIT2
    send(32'h6000_0000, 1'b1);
    chk("Cpl init",  int'(is_initFC_o), 1);
    chk("Cpl hdr",   int'(hdr_credit_o), 0);
    chk("Cpl data",  int'(data_credit_o), 0);
    chk("Cpl type",  int'(type_credit_o), 2);
    chk("init2 state", int'(fc_state_o), 2);
    chk("init2 req",   int'(tx_initfc_req_o), 1);

    // INIT2: InitFC1 and InitFC2 are not forwarded
    send(32'h4001_4080, 1'b1);
    chk("init2 initfc1 fwd", int'(is_initFC_o), 0);
    send(32'hC001_4080, 1'b1);
    chk("init2 initfc2 fwd", int'(is_initFC_o), 0);
    chk("init2 hold state",  int'(fc_state_o), 2);
    pulses = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (tx_initfc_req_o) pulses++;
    end
    chk("pace count init2", pulses, 1);

    // UpdateFC Cpl in INIT2 -> ACTIVE and forwarded
    send(32'hA000_8100, 1'b1);
    chk("upd2 upd",   int'(is_updateFC_o), 1);
    chk("upd2 hdr",   int'(hdr_credit_o), 8'h02);
    chk("upd2 data",  int'(data_credit_o), 12'h100);
    chk("upd2 type",  int'(type_credit_o), 2);
    chk("upd2 done",  int'(fc_init_done_o), 1);
    chk("upd2 state", int'(fc_state_o), 3);
    chk("upd2 req",   int'(tx_initfc_req_o), 0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (tx_initfc_req_o) pulses++;
    end
    chk("pace count active", pulses, 0);

    // ACTIVE: UpdateFC with max field values, InitFC ignored
    send(32'h803F_CFFF, 1'b1);
    chk("max upd",  int'(is_updateFC_o), 1);
    chk("max hdr",  int'(hdr_credit_o), 8'hFF);
    chk("max data", int'(data_credit_o), 12'hFFF);
    chk("max type", int'(type_credit_o), 0);
    send(32'h5003_0405, 1'b1);
    chk("active initfc1", int'(is_initFC_o), 0);
    chk("active hold hdr", int'(hdr_credit_o), 8'hFF);
    chk("active no count", int'(drop_cnt_o), 3);

    // Saturation
    for (int i = 0; i < 300; i++) send(32'h8000_0000, 1'b0);
    chk("drop saturate", int'(drop_cnt_o), 8'hFF);

    // Link down concurrent with a valid UpdateFC
    link_up = 1'b0;
    send(32'hA000_8100, 1'b1);
    chk("linkdown upd",   int'(is_updateFC_o), 0);
    chk("linkdown state", int'(fc_state_o), 0);
    chk("linkdown hdr",   int'(hdr_credit_o), 8'hFF);
    chk("linkdown drop",  int'(drop_cnt_o), 8'hFF);
    tick();

    // Relink: full sequence required again
    link_up = 1'b1;
    tick();
    chk("relink state", int'(fc_state_o), 1);
    chk("relink req",   int'(tx_initfc_req_o), 1);
    send(32'hE000_0000, 1'b1);
    chk("relink initfc2 ignored", int'(fc_state_o), 1);
    send(32'h4001_4080, 1'b1);
    chk("relink P", int'(is_initFC_o), 1);
    send(32'h5003_0405, 1'b1);
    chk("relink NP", int'(is_initFC_o), 1);
    send(32'h6000_0000, 1'b1);
    chk("relink init2", int'(fc_state_o), 2);
    send(32'hC000_0000, 1'b1);
    send(32'hD000_0000, 1'b1);
    chk("relink half", int'(fc_state_o), 2);
    send(32'hE000_0000, 1'b1);
    chk("relink active", int'(fc_state_o), 3);
    chk("relink done",   int'(fc_init_done_o), 1);
    chk("relink no upd", int'(is_updateFC_o), 0);
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
